// File: rtl/robot_motor_pkg.sv
// -----------------------------------------------------------------------------
// robot_motor_pkg
// Shared definitions for the stepper-motor back end of the wall-following
// robot:
//   state_e      - top-level FSM states (IDLE, ADVANCE, ROTATE, FAULT)
//   FWD / BWD    - step direction encoding used by stepper_phase_gen
//   PHASE_RESET  - coil pattern for phase index 0
//   ODO_W        - odometer width
//   phase_decode - 2-bit phase index to one-hot coil drive
// -----------------------------------------------------------------------------
package robot_motor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADVANCE = 2'd1,
      ROTATE  = 2'd2,
      FAULT   = 2'd3
   } state_e;

   localparam logic FWD = 1'b0;
   localparam logic BWD = 1'b1;

   localparam logic [3:0] PHASE_RESET = 4'b0001;

   localparam int ODO_W = 16;

   // Index 0..3 energizes coil 0..3; shifting the reset pattern keeps the
   // index-0 pattern and the decode in one place.
   function automatic logic [3:0] phase_decode(input logic [1:0] idx);
      return PHASE_RESET << idx;
   endfunction

endpackage

// File: rtl/robot_motor_driver_phase_gen.sv
// -----------------------------------------------------------------------------
// stepper_phase_gen
// Full-step wave sequencer for one wheel. Holds a 2-bit phase index that moves
// one position per enabled cycle in the requested direction and drives the
// matching one-hot coil pattern. The index is never cleared except by reset,
// so the last energized coil stays on for holding torque.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset (index -> 0)
//   step_en  in   advance the index by one position this cycle
//   dir      in   FWD: index + 1 mod 4, BWD: index - 1 mod 4
//   phase    out  one-hot coil drive for the current index
// -----------------------------------------------------------------------------
module stepper_phase_gen
   import robot_motor_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   input  logic       dir,
   output logic [3:0] phase
);

   logic [1:0] idx_q;
   logic [1:0] idx_d;

   // 2-bit arithmetic gives the mod-4 wrap in both directions for free.
   always_comb begin
      idx_d = idx_q;
      if (step_en) begin
         if (dir == FWD) begin
            idx_d = idx_q + 2'd1;
         end else begin
            idx_d = idx_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= 2'd0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign phase = phase_decode(idx_q);

endmodule

// File: rtl/robot_motor_driver.sv
// -----------------------------------------------------------------------------
// robot_motor_driver
// Stepper back end for the wall-following robot controller. Converts the
// controller's advance (a) / rotate (r) command levels into full-step wave
// sequences for the left and right wheels, paced by a STEP_DIV clock divider.
// Rotations run as uninterruptible quanta of TURN_STEPS steps (clockwise in
// place: left forward, right backward). Simultaneous a and r is illegal and
// parks the driver in FAULT with the coils de-energized until both drop.
// Parameters:
//   STEP_DIV    clock cycles per step tick (>= 2)
//   TURN_STEPS  steps per rotation quantum (>= 1)
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   a            in   advance request (level)
//   r            in   rotate request (level)
//   left_phase   out  left coil drive, one-hot or zero in FAULT
//   right_phase  out  right coil drive, one-hot or zero in FAULT
//   busy         out  high in ADVANCE or ROTATE
//   done         out  one-cycle pulse after the last step of a rotation
//   fault        out  high in FAULT
//   odometer     out  advance step count, wraps mod 2^ODO_W
// -----------------------------------------------------------------------------
module robot_motor_driver
   import robot_motor_pkg::*;
#(
   parameter int STEP_DIV   = 4,
   parameter int TURN_STEPS = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             a,
   input  logic             r,
   output logic [3:0]       left_phase,
   output logic [3:0]       right_phase,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [ODO_W-1:0] odometer
);

   localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int TURN_W = $clog2(TURN_STEPS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_STEPS - 1);

   generate
      if (STEP_DIV < 2) begin : g_bad_step_div
         $error("robot_motor_driver: STEP_DIV must be at least 2");
      end
      if (TURN_STEPS < 1) begin : g_bad_turn_steps
         $error("robot_motor_driver: TURN_STEPS must be at least 1");
      end
   endgenerate

   state_e            state_q;
   state_e            state_d;
   logic [TICK_W-1:0] tick_q;
   logic [TICK_W-1:0] tick_d;
   logic [TURN_W-1:0] turn_q;
   logic [TURN_W-1:0] turn_d;
   logic [ODO_W-1:0]  odometer_q;
   logic [ODO_W-1:0]  odometer_d;
   logic              done_q;
   logic              done_d;

   logic              tick;
   logic              adv_step;
   logic              rot_step;
   logic              wheel_step;
   logic              right_dir;
   logic [3:0]        left_raw;
   logic [3:0]        right_raw;

   // A tick is the last cycle of each STEP_DIV-long step period.
   assign tick = (tick_q == TICK_LAST);

   // ---------------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      tick_d     = '0;
      turn_d     = turn_q;
      odometer_d = odometer_q;
      done_d     = 1'b0;
      adv_step   = 1'b0;
      rot_step   = 1'b0;

      case (state_q)
         IDLE: begin
            // Tick counter already idles at zero, so entering a motion
            // state starts a fresh step period.
            turn_d = '0;
            if (a && r) begin
               state_d = FAULT;
            end else if (a) begin
               state_d = ADVANCE;
            end else if (r) begin
               state_d = ROTATE;
            end
         end

         ADVANCE: begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
            // Commands only matter at the tick; a stop request therefore
            // waits for the end of the current step period.
            if (tick) begin
               if (!a) begin
                  state_d = IDLE;
               end else if (r) begin
                  state_d = FAULT;
               end else begin
                  adv_step   = 1'b1;
                  odometer_d = odometer_q + ODO_W'(1);
               end
            end
         end

         ROTATE: begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
            // a and r are deliberately not looked at: the quantum always
            // completes so the heading changes by a fixed angle.
            if (tick) begin
               rot_step = 1'b1;
               if (turn_q == TURN_LAST) begin
                  turn_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  turn_d = turn_q + TURN_W'(1);
               end
            end
         end

         FAULT: begin
            if (!a && !r) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         turn_q     <= '0;
         odometer_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         turn_q     <= turn_d;
         odometer_q <= odometer_d;
         done_q     <= done_d;
      end
   end

   // ---------------------------------------------------------------------
   // Wheel sequencers: both wheels step together; only the right wheel
   // reverses direction during a rotation.
   // ---------------------------------------------------------------------
   assign wheel_step = adv_step | rot_step;
   assign right_dir  = rot_step ? BWD : FWD;

   stepper_phase_gen u_left (
      .clk     (clk),
      .reset   (reset),
      .step_en (wheel_step),
      .dir     (FWD),
      .phase   (left_raw)
   );

   stepper_phase_gen u_right (
      .clk     (clk),
      .reset   (reset),
      .step_en (wheel_step),
      .dir     (right_dir),
      .phase   (right_raw)
   );

   // ---------------------------------------------------------------------
   // Outputs. FAULT only blanks the coil drive; the stored phase indices
   // are untouched so motion resumes from the same rotor position.
   // ---------------------------------------------------------------------
   assign left_phase  = (state_q == FAULT) ? 4'b0000 : left_raw;
   assign right_phase = (state_q == FAULT) ? 4'b0000 : right_raw;
   assign busy        = (state_q == ADVANCE) || (state_q == ROTATE);
   assign fault       = (state_q == FAULT);
   assign done        = done_q;
   assign odometer    = odometer_q;

endmodule

// File: tb/tb_robot_motor_driver.sv
// -----------------------------------------------------------------------------
// tb_robot_motor_driver
// Scoreboard bench: stimulus pushes every expected output change (with the
// clock count at which it must appear) into a queue; the monitor samples the
// outputs on each falling edge and pops one entry whenever anything changes.
// -----------------------------------------------------------------------------
module tb_robot_motor_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        a = 1'b0;
   logic        r = 1'b0;
   logic [3:0]  left_phase;
   logic [3:0]  right_phase;
   logic        busy;
   logic        done;
   logic        fault;
   logic [15:0] odometer;

   robot_motor_driver #(.STEP_DIV(4), .TURN_STEPS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .a           (a),
      .r           (r),
      .left_phase  (left_phase),
      .right_phase (right_phase),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .odometer    (odometer)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int          cyc;     // -1: any cycle
      logic [3:0]  l;
      logic [3:0]  rp;
      logic        b;
      logic        d;
      logic        f;
      logic [15:0] o;
   } snap_t;

   snap_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 1'b0;

   // Expected-state model (stored phases, flags, odometer)
   logic [3:0]  m_l = 4'b0001;
   logic [3:0]  m_r = 4'b0001;
   logic        m_b = 1'b0;
   logic        m_d = 1'b0;
   logic        m_f = 1'b0;
   logic [15:0] m_o = 16'h0000;

   function automatic logic [3:0] fwd(input logic [3:0] x);
      return {x[2:0], x[3]};
   endfunction

   function automatic logic [3:0] bwd(input logic [3:0] x);
      return {x[0], x[3:1]};
   endfunction

   task automatic push(input string name, input int c);
      snap_t s;
      s.name = name;
      s.cyc  = c;
      s.l    = m_f ? 4'b0000 : m_l;
      s.rp   = m_f ? 4'b0000 : m_r;
      s.b    = m_b;
      s.d    = m_d;
      s.f    = m_f;
      s.o    = m_o;
      exp_q.push_back(s);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin : monitor
      logic [26:0] prev;
      logic [26:0] cur;
      bit          have_prev;
      snap_t       e;
      have_prev = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = {left_phase, right_phase, busy, done, fault, odometer};
            if (!have_prev || cur !== prev) begin
               have_prev = 1'b1;
               prev      = cur;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_change cyc=%0d got l=%b r=%b busy=%b done=%b fault=%b odo=%h, no change required",
                           cyc, left_phase, right_phase, busy, done, fault, odometer);
               end else begin
                  e = exp_q.pop_front();
                  if ((e.cyc != -1 && e.cyc != cyc) || left_phase !== e.l ||
                      right_phase !== e.rp || busy !== e.b || done !== e.d ||
                      fault !== e.f || odometer !== e.o) begin
                     errors++;
                     $display("FAIL %s got cyc=%0d l=%b r=%b busy=%b done=%b fault=%b odo=%h required cyc=%0d l=%b r=%b busy=%b done=%b fault=%b odo=%h",
                              e.name, cyc, left_phase, right_phase, busy, done, fault, odometer,
                              e.cyc, e.l, e.rp, e.b, e.d, e.f, e.o);
                  end else begin
                     $display("ok   %s cyc=%0d l=%b r=%b busy=%b done=%b fault=%b odo=%h",
                              e.name, cyc, left_phase, right_phase, busy, done, fault, odometer);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cyc=%0d, simulation did not complete", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin : stimulus
      int n;

      // 1. Reset release, idle for 20 cycles: no output may change.
      repeat (3) @(negedge clk);
      reset = 1'b1;
      push("reset_state", -1);
      mon_en = 1'b1;
      repeat (20) @(negedge clk);

      // 2. Advance held 18 cycles: four forward steps, stop at next tick.
      n = cyc;
      a = 1'b1;
      m_b = 1'b1; push("adv_busy_rise", n + 1);
      for (int j = 1; j <= 4; j++) begin
         m_l = fwd(m_l); m_r = fwd(m_r); m_o = m_o + 16'd1;
         push("adv_step", n + 1 + 4 * j);
      end
      m_b = 1'b0; push("adv_busy_fall", n + 21);
      wait_until(n + 18);
      a = 1'b0;
      wait_until(n + 26);

      // 3. One-cycle rotate pulse; an illegal a/r pair mid-quantum is ignored.
      n = cyc;
      r = 1'b1;
      m_b = 1'b1; push("rot_busy_rise", n + 1);
      for (int j = 1; j <= 8; j++) begin
         m_l = fwd(m_l); m_r = bwd(m_r);
         if (j == 8) begin
            m_b = 1'b0; m_d = 1'b1;
            push("rot_last_step_done", n + 1 + 4 * j);
         end else begin
            push("rot_step", n + 1 + 4 * j);
         end
      end
      m_d = 1'b0; push("rot_done_fall", n + 34);
      wait_until(n + 1);
      r = 1'b0;
      wait_until(n + 10);
      a = 1'b1; r = 1'b1;
      wait_until(n + 11);
      a = 1'b0; r = 1'b0;
      wait_until(n + 40);

      // 5. r rises during ADVANCE: fault at next tick with no extra step.
      n = cyc;
      a = 1'b1;
      m_b = 1'b1; push("adv2_busy_rise", n + 1);
      for (int j = 1; j <= 2; j++) begin
         m_l = fwd(m_l); m_r = fwd(m_r); m_o = m_o + 16'd1;
         push("adv2_step", n + 1 + 4 * j);
      end
      m_b = 1'b0; m_f = 1'b1; push("adv2_fault", n + 13);
      m_f = 1'b0; push("adv2_fault_clear", n + 17);
      wait_until(n + 10);
      r = 1'b1;
      wait_until(n + 16);
      a = 1'b0; r = 1'b0;
      wait_until(n + 22);

      // 4. a=r=1 from IDLE: fault, then phases restored on release.
      n = cyc;
      a = 1'b1; r = 1'b1;
      m_f = 1'b1; push("idle_fault", n + 1);
      m_f = 1'b0; push("idle_fault_clear", n + 4);
      wait_until(n + 3);
      a = 1'b0; r = 1'b0;
      wait_until(n + 8);

      // 6. Async reset right after the fifth rotation step.
      n = cyc;
      r = 1'b1;
      m_b = 1'b1; push("rot2_busy_rise", n + 1);
      for (int j = 1; j <= 4; j++) begin
         m_l = fwd(m_l); m_r = bwd(m_r);
         push("rot2_step", n + 1 + 4 * j);
      end
      m_l = 4'b0001; m_r = 4'b0001; m_b = 1'b0; m_o = 16'h0000;
      push("async_reset_mid_rotate", n + 21);
      wait_until(n + 1);
      r = 1'b0;
      wait_until(n + 20);
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);

      // Odometer wrap: preload to 0xFFFE, then three advance steps.
      @(posedge clk);
      #2;
      force dut.odometer_q = 16'hFFFE;
      m_o = 16'hFFFE; push("odo_preload", cyc);
      @(posedge clk);
      #2;
      release dut.odometer_q;
      repeat (2) @(negedge clk);
      n = cyc;
      a = 1'b1;
      m_b = 1'b1; push("wrap_busy_rise", n + 1);
      for (int j = 1; j <= 3; j++) begin
         m_l = fwd(m_l); m_r = fwd(m_r); m_o = m_o + 16'd1;
         push("wrap_step", n + 1 + 4 * j);
      end
      m_b = 1'b0; push("wrap_busy_fall", n + 17);
      wait_until(n + 14);
      a = 1'b0;
      wait_until(n + 24);

      while (exp_q.size() > 0) begin
         snap_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s missing: required change at cyc=%0d never observed (now cyc=%0d)",
                  e.name, e.cyc, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
